// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the RV32I MEM/WB stage.
// Result select, load/store sizes and FSM state codes.
package mem_wb_stage_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_REQ  = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/grant/response port.
// The stage is master; the memory (or cache) is slave.
interface mem_wb_stage_if;

   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );

endinterface

// File: rtl/mem_wb_stage_align.sv
// Lane steering for loads and stores: byte enables, store replication,
// misalignment detection and load extraction with sign/zero extension.
module load_store_align
   import mem_wb_stage_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misaligned,
   output logic [31:0] o_load_data
);

   logic        w_byte;
   logic        w_half;
   logic        w_sext;
   logic [31:0] w_lane;

   always_comb begin
      w_byte = (i_funct3[1:0] == SZ_B);
      w_half = (i_funct3[1:0] == SZ_H);
      w_sext = !((i_funct3 == F3_LBU) || (i_funct3 == F3_LHU));
      w_lane = i_rdata >> {i_addr, 3'b000};

      o_be         = 4'hF;
      o_wdata      = i_store_data;
      o_misaligned = 1'b0;
      o_load_data  = i_rdata;

      unique case (1'b1)
         w_byte: begin
            o_be        = 4'b0001 << i_addr;
            o_wdata     = {4{i_store_data[7:0]}};
            o_load_data = {{24{w_sext & w_lane[7]}}, w_lane[7:0]};
         end
         w_half: begin
            o_be         = 4'b0011 << i_addr;
            o_wdata      = {2{i_store_data[15:0]}};
            o_misaligned = i_addr[0];
            o_load_data  = {{16{w_sext & w_lane[15]}}, w_lane[15:0]};
         end
         default: begin
            o_misaligned = |i_addr;
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Combined MEM/WB stage: runs one load/store at a time on the dmem port
// and drives the register-file write port with a one-cycle strobe.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic [31:0] ex_pc_plus_4,
   input  logic [4:0]  ex_rd,
   input  logic        ex_regwrite,
   input  logic [1:0]  ex_result_src,
   input  logic        ex_memwrite,
   input  logic [2:0]  ex_funct3,
   mem_wb_stage_if.master dmem,
   output logic        wb_regwrite,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_misaligned,
   output logic        wb_bus_error
);

   localparam logic [31:0] LP_LAST = WAIT_LIMIT - 1;

   logic [1:0]  r_state;
   logic [31:0] r_wait;
   logic [31:0] r_addr;
   logic [31:0] r_sdata;
   logic [2:0]  r_funct3;
   logic        r_we;
   logic [4:0]  r_rd;
   logic        r_regwrite;

   logic        r_wb_we;
   logic [4:0]  r_wb_rd;
   logic [31:0] r_wb_data;
   logic        r_wb_mis;
   logic        r_wb_berr;

   logic        w_idle;
   logic        w_req;
   logic        w_acc;
   logic        w_is_mem;
   logic        w_wr_en;
   logic        w_expire;
   logic [31:0] w_alu_data;
   logic [2:0]  w_f3;
   logic [1:0]  w_a;
   logic [31:0] w_sd;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic        w_mis;
   logic [31:0] w_load;

   // Align unit sees the incoming bundle in IDLE, the captured one otherwise
   assign w_idle = (r_state == ST_IDLE);
   assign w_req  = (r_state == ST_REQ);
   assign w_f3   = w_idle ? ex_funct3 : r_funct3;
   assign w_a    = w_idle ? ex_alu_result[1:0] : r_addr[1:0];
   assign w_sd   = w_idle ? ex_store_data : r_sdata;

   load_store_align u_align (
      .i_funct3     (w_f3),
      .i_addr       (w_a),
      .i_store_data (w_sd),
      .i_rdata      (dmem.dmem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_misaligned (w_mis),
      .o_load_data  (w_load)
   );

   assign ex_ready = w_idle;
   assign w_acc    = ex_valid && w_idle;
   assign w_is_mem = ex_memwrite || (ex_result_src == RES_MEM);
   assign w_wr_en  = ex_regwrite && (ex_rd != 5'd0);
   assign w_expire = (WAIT_LIMIT != 0) && (r_wait == LP_LAST);

   always_comb begin
      w_alu_data = ex_alu_result;
      case (ex_result_src)
         RES_PC4: w_alu_data = ex_pc_plus_4;
         RES_ALU: w_alu_data = ex_alu_result;
         default: w_alu_data = ex_alu_result;
      endcase
   end

   assign dmem.dmem_req   = w_req;
   assign dmem.dmem_we    = w_req & r_we;
   assign dmem.dmem_addr  = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
   assign dmem.dmem_be    = w_req ? w_be : 4'd0;
   assign dmem.dmem_wdata = w_req ? w_wdata : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_wait     <= '0;
         r_addr     <= '0;
         r_sdata    <= '0;
         r_funct3   <= '0;
         r_we       <= 1'b0;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
         r_wb_we    <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_wb_mis   <= 1'b0;
         r_wb_berr  <= 1'b0;
      end else begin
         r_wb_we   <= 1'b0;
         r_wb_mis  <= 1'b0;
         r_wb_berr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_acc && !w_is_mem) begin
                  if (w_wr_en) begin
                     r_wb_we   <= 1'b1;
                     r_wb_rd   <= ex_rd;
                     r_wb_data <= w_alu_data;
                  end
               end else if (w_acc && w_mis) begin
                  r_wb_mis <= 1'b1;
               end else if (w_acc) begin
                  r_state    <= ST_REQ;
                  r_wait     <= '0;
                  r_addr     <= ex_alu_result;
                  r_sdata    <= ex_store_data;
                  r_funct3   <= ex_funct3;
                  r_we       <= ex_memwrite;
                  r_rd       <= ex_rd;
                  r_regwrite <= w_wr_en;
               end
            end
            ST_REQ: begin
               if (dmem.dmem_gnt) begin
                  r_state <= r_we ? ST_IDLE : ST_RESP;
                  r_wait  <= '0;
               end else if (w_expire) begin
                  r_state   <= ST_IDLE;
                  r_wait    <= '0;
                  r_wb_berr <= 1'b1;
               end else begin
                  r_wait <= r_wait + 32'd1;
               end
            end
            ST_RESP: begin
               if (dmem.dmem_rvalid) begin
                  r_state <= ST_IDLE;
                  r_wait  <= '0;
                  if (r_regwrite) begin
                     r_wb_we   <= 1'b1;
                     r_wb_rd   <= r_rd;
                     r_wb_data <= w_load;
                  end
               end else if (w_expire) begin
                  r_state   <= ST_IDLE;
                  r_wait    <= '0;
                  r_wb_berr <= 1'b1;
               end else begin
                  r_wait <= r_wait + 32'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign wb_regwrite   = r_wb_we;
   assign wb_rd         = r_wb_rd;
   assign wb_data       = r_wb_data;
   assign wb_misaligned = r_wb_mis;
   assign wb_bus_error  = r_wb_berr;

endmodule
